// File: rtl/tube_scan_driver_if.sv
// ---------------------------------------------------------------------------
// tube_scan_driver_if
//   Bus between the CPU-side display register and the tube scan driver.
//   master : drives the display value and load strobe, observes status/pins.
//   slave  : the driver itself.
//   Signals:
//     data_in     value to display, sampled on load
//     load        single-cycle capture strobe
//     mode        0 = hex, 1 = unsigned decimal
//     blank_lz    1 = blank leading zero digits
//     dp_mask     decimal point per digit, bit 0 = rightmost digit
//     busy        decimal conversion in progress
//     ovf         last decimal value did not fit in DIGITS digits
//     tube_scan   one-hot digit enable
//     tube_signal segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
interface tube_scan_driver_if #(
  parameter int DIGITS = 8,
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_in;
  logic              load;
  logic              mode;
  logic              blank_lz;
  logic [DIGITS-1:0] dp_mask;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] tube_scan;
  logic [7:0]        tube_signal;

  modport master (
    output data_in, load, mode, blank_lz, dp_mask,
    input  busy, ovf, tube_scan, tube_signal
  );

  modport slave (
    input  data_in, load, mode, blank_lz, dp_mask,
    output busy, ovf, tube_scan, tube_signal
  );
endinterface

// File: rtl/tube_scan_driver.sv
// ---------------------------------------------------------------------------
// tube_scan_driver
//   Multiplexed seven-segment driver for DIGITS digits. A load captures a
//   DATA_W-bit value shown either as hex or as unsigned decimal; decimal
//   values go through a bit-serial double-dabble converter (DATA_W shift
//   cycles plus one commit cycle). Supports per-digit decimal points,
//   leading-zero blanking and a dash pattern on decimal overflow.
//   Ports:
//     clk_100  system clock
//     rst      asynchronous active-high reset
//     bus      tube_scan_driver_if slave modport (load side + tube pins)
// ---------------------------------------------------------------------------
module tube_scan_driver #(
  parameter int DIGITS         = 8,
  parameter int DATA_W         = 32,
  parameter int SCAN_DIV       = 100000,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic               clk_100,
  input  logic               rst,
  tube_scan_driver_if.slave  bus
);

  // ceil(DATA_W * 0.302) + 1 BCD digits always hold a DATA_W-bit value;
  // never narrower than the display so the commit slice is always valid.
  localparam int BCD_DIGITS = (DATA_W * 302 + 999) / 1000 + 1;
  localparam int BCD_N      = (BCD_DIGITS > DIGITS) ? BCD_DIGITS : DIGITS;
  localparam int BCD_W      = BCD_N * 4;
  localparam int DISP_W     = DIGITS * 4;
  localparam int EXT_W      = (DATA_W > DISP_W) ? DATA_W : DISP_W;
  localparam int CNT_W      = $clog2(DATA_W);
  localparam int SCAN_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Add 3 to every BCD nibble that is 5 or more (double-dabble correction).
  function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < BCD_N; i++) begin
      if (v[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = v[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Segment pattern {g,f,e,d,c,b,a} for a nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [BCD_W-1:0]  bcd_q, bcd_d;
  logic [BCD_W-1:0]  bcd_adj;
  logic [DISP_W-1:0] disp_q, disp_d;
  logic [DIGITS-1:0] dp_q, dp_d;
  logic              blank_q, blank_d;
  logic              ovf_q, ovf_d;
  logic [DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic              pend_blank_q, pend_blank_d;

  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              scan_last;

  logic [DIGITS-1:0] lz;
  logic              zero_run;
  logic [3:0]        cur_nib;
  logic [6:0]        cur_seg;
  logic [DIGITS-1:0] tube_scan_q, tube_scan_d;
  logic [7:0]        tube_signal_q, tube_signal_d;

  assign bcd_adj = bcd_adjust(bcd_q);

  // Load capture and decimal conversion.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    bcd_d        = bcd_q;
    disp_d       = disp_q;
    dp_d         = dp_q;
    blank_d      = blank_q;
    ovf_d        = ovf_q;
    pend_dp_d    = pend_dp_q;
    pend_blank_d = pend_blank_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.load) begin
          if (!bus.mode) begin
            disp_d  = DISP_W'(EXT_W'(bus.data_in));
            dp_d    = bus.dp_mask;
            blank_d = bus.blank_lz;
            ovf_d   = 1'b0;
          end else begin
            // Display attributes are held back so the old value stays
            // intact on the tubes until the converted digits are committed.
            state_d      = ST_SHIFT;
            bcd_d        = '0;
            sh_d         = bus.data_in;
            cnt_d        = '0;
            pend_dp_d    = bus.dp_mask;
            pend_blank_d = bus.blank_lz;
          end
        end
      end
      ST_SHIFT: begin
        bcd_d = BCD_W'({bcd_adj, sh_q[DATA_W-1]});
        sh_d  = sh_q << 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        disp_d  = bcd_q[DISP_W-1:0];
        ovf_d   = |(bcd_q >> DISP_W);
        dp_d    = pend_dp_q;
        blank_d = pend_blank_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Digit scan timing.
  always_comb begin
    scan_last  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_last ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = idx_q;
    if (scan_last) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
  end

  // Segment generation for the digit currently selected by idx_q.
  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    // A digit is a leading zero if it and every digit to its left are zero.
    for (int i = DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (disp_q[i*4 +: 4] == 4'd0);
      lz[i]    = zero_run & (i != 0);
    end
    cur_nib = disp_q[{idx_q, 2'b00} +: 4];
    if (ovf_q)                    cur_seg = 7'h40;
    else if (blank_q && lz[idx_q]) cur_seg = 7'h00;
    else                          cur_seg = seg7(cur_nib);
    tube_signal_d = {dp_q[idx_q], cur_seg};
    tube_scan_d   = DIGITS'(1) << idx_q;
  end

  always_ff @(posedge clk_100 or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sh_q          <= '0;
      bcd_q         <= '0;
      disp_q        <= '0;
      dp_q          <= '0;
      blank_q       <= 1'b0;
      ovf_q         <= 1'b0;
      pend_dp_q     <= '0;
      pend_blank_q  <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      tube_scan_q   <= '0;
      tube_signal_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sh_q          <= sh_d;
      bcd_q         <= bcd_d;
      disp_q        <= disp_d;
      dp_q          <= dp_d;
      blank_q       <= blank_d;
      ovf_q         <= ovf_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      tube_scan_q   <= tube_scan_d;
      tube_signal_q <= tube_signal_d;
    end
  end

  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.ovf         = ovf_q;
  // Polarity applied after the registers so reset shows all-off either way.
  assign bus.tube_scan   = (SEG_ACTIVE_LOW != 0) ? ~tube_scan_q : tube_scan_q;
  assign bus.tube_signal = (SEG_ACTIVE_LOW != 0) ? ~tube_signal_q : tube_signal_q;

endmodule

// File: tb/tb_tube_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_tube_scan_driver
//   Self-checking bench for tube_scan_driver (DIGITS=8, DATA_W=32,
//   SCAN_DIV=4, active-high outputs). Expected digits are computed from the
//   displayed value with division/shift arithmetic.
// ---------------------------------------------------------------------------
module tb_tube_scan_driver;
  localparam int DIGITS   = 8;
  localparam int DATA_W   = 32;
  localparam int SCAN_DIV = 4;

  logic clk_100 = 1'b0;
  logic rst     = 1'b1;
  always #5 clk_100 = ~clk_100;

  tube_scan_driver_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  tube_scan_driver #(
    .DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV), .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk_100(clk_100),
    .rst    (rst),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] seg_tab [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                 8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference state: what the display should currently be showing.
  logic [31:0] m_val;
  bit          m_dec;
  bit          m_blank;
  logic [7:0]  m_dp;

  logic [7:0] obs_seg  [0:DIGITS-1];
  bit         obs_seen [0:DIGITS-1];
  int         bad_onehot;

  function automatic bit exp_ovf();
    return m_dec && (m_val >= 32'd100000000);
  endfunction

  function automatic logic [7:0] exp_seg(input int i);
    longint unsigned v, p10, q;
    int dv;
    logic [7:0] r;
    v   = {32'd0, m_val};
    p10 = 1;
    for (int k = 0; k < i; k++) p10 = p10 * 10;
    if (m_dec) begin
      if (v >= 64'd100000000) r = 8'h40;
      else begin
        q  = v / p10;
        dv = int'(q % 10);
        if (m_blank && i > 0 && q == 0) r = 8'h00;
        else r = seg_tab[dv];
      end
    end else begin
      q  = v >> (4 * i);
      dv = int'(q & 64'd15);
      if (m_blank && i > 0 && q == 0) r = 8'h00;
      else r = seg_tab[dv];
    end
    r[7] = m_dp[i];
    return r;
  endfunction

  function automatic int scan_index();
    int idx;
    idx = -1;
    for (int d = 0; d < DIGITS; d++) if (bus.tube_scan === (8'(1) << d)) idx = d;
    return idx;
  endfunction

  task automatic model_reset();
    m_val = 0; m_dec = 0; m_blank = 0; m_dp = 0;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_100);
  endtask

  // Presents a load for one clock; returns at the negedge after capture.
  task automatic drive_load(input logic [31:0] v, input bit dec, input bit bl,
                            input logic [7:0] dp);
    bus.data_in  = v;
    bus.mode     = dec;
    bus.blank_lz = bl;
    bus.dp_mask  = dp;
    bus.load     = 1'b1;
    @(negedge clk_100);
    bus.load     = 1'b0;
  endtask

  task automatic wait_idle(output bit timed_out);
    int k;
    k = 0;
    timed_out = 0;
    while (bus.busy === 1'b1) begin
      @(negedge clk_100);
      k++;
      if (k > 200) begin
        timed_out = 1;
        break;
      end
    end
  endtask

  // Observes one full scan round and records the segments seen per digit.
  task automatic capture();
    int idx;
    bad_onehot = 0;
    for (int d = 0; d < DIGITS; d++) begin
      obs_seen[d] = 0;
      obs_seg[d]  = 8'h00;
    end
    repeat (DIGITS * SCAN_DIV + 2) begin
      @(negedge clk_100);
      idx = scan_index();
      if (idx < 0) bad_onehot++;
      else begin
        obs_seg[idx]  = bus.tube_signal;
        obs_seen[idx] = 1;
      end
    end
  endtask

  task automatic test_reset();
    cyc(2);
    n_total++; if (bus.tube_scan !== 8'h00) $display("FAIL reset_scan: got %h want 00", bus.tube_scan); else n_pass++;
    n_total++; if (bus.tube_signal !== 8'h00) $display("FAIL reset_seg: got %h want 00", bus.tube_signal); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else n_pass++;
  endtask

  task automatic test_scan();
    logic [7:0] want;
    model_reset();
    rst = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk_100);
      want = 8'(1) << ((k / SCAN_DIV) % DIGITS);
      n_total++;
      if (bus.tube_scan !== want) $display("FAIL scan_seq k=%0d: got %h want %h", k, bus.tube_scan, want);
      else n_pass++;
      n_total++;
      if (bus.tube_signal !== exp_seg((k / SCAN_DIV) % DIGITS))
        $display("FAIL scan_seg k=%0d: got %h want %h", k, bus.tube_signal, exp_seg((k / SCAN_DIV) % DIGITS));
      else n_pass++;
    end
  endtask

  task automatic check_round(input string name);
    capture();
    n_total++;
    if (bad_onehot != 0) $display("FAIL %s_onehot: got %0d bad samples want 0", name, bad_onehot);
    else n_pass++;
    for (int d = 0; d < DIGITS; d++) begin
      n_total++;
      if (!obs_seen[d] || obs_seg[d] !== exp_seg(d))
        $display("FAIL %s_digit%0d: got %h (seen %0d) want %h", name, d, obs_seg[d], obs_seen[d], exp_seg(d));
      else n_pass++;
    end
  endtask

  task automatic test_hex();
    drive_load(32'h0000_00F7, 0, 0, 8'h00);
    m_val = 32'h0000_00F7; m_dec = 0; m_blank = 0; m_dp = 0;
    for (int k = 0; k < 4; k++) begin
      n_total++; if (bus.busy !== 1'b0) $display("FAIL hex_busy k=%0d: got %b want 0", k, bus.busy); else n_pass++;
      @(negedge clk_100);
    end
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL hex_ovf: got %b want 0", bus.ovf); else n_pass++;
    check_round("hex");
  endtask

  task automatic test_decimal();
    int idx;
    // Old value (hex F7) must stay on the tubes until the conversion commits.
    drive_load(32'd12345678, 1, 0, 8'h00);
    for (int n = 1; n <= 34; n++) begin
      n_total++;
      if (bus.busy !== (n <= 33)) $display("FAIL dec_busy n=%0d: got %b want %b", n, bus.busy, (n <= 33));
      else n_pass++;
      idx = scan_index();
      n_total++;
      if (idx < 0 || bus.tube_signal !== exp_seg(idx))
        $display("FAIL dec_old n=%0d: got %h on scan %h want %h", n, bus.tube_signal, bus.tube_scan, (idx < 0) ? 8'h00 : exp_seg(idx));
      else n_pass++;
      if (n < 34) @(negedge clk_100);
    end
    m_val = 32'd12345678; m_dec = 1; m_blank = 0; m_dp = 0;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL dec_ovf: got %b want 0", bus.ovf); else n_pass++;
    check_round("dec");
  endtask

  task automatic test_overflow();
    bit to;
    drive_load(32'd100000000, 1, 0, 8'h00);
    wait_idle(to);
    n_total++; if (to) $display("FAIL ovf_timeout: got busy stuck want idle"); else n_pass++;
    m_val = 32'd100000000; m_dec = 1; m_blank = 0; m_dp = 0;
    cyc(2);
    n_total++; if (bus.ovf !== 1'b1) $display("FAIL ovf_flag: got %b want 1", bus.ovf); else n_pass++;
    check_round("ovf");
  endtask

  task automatic test_blank_dp();
    bit to;
    drive_load(32'd42, 1, 1, 8'h04);
    wait_idle(to);
    n_total++; if (to) $display("FAIL blank_timeout: got busy stuck want idle"); else n_pass++;
    m_val = 32'd42; m_dec = 1; m_blank = 1; m_dp = 8'h04;
    cyc(2);
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL blank_ovf: got %b want 0", bus.ovf); else n_pass++;
    check_round("blank");
  endtask

  task automatic test_back_to_back();
    int falls;
    logic prev;
    falls = 0;
    drive_load(32'd987654, 1, 0, 8'h01);
    prev = bus.busy;
    for (int n = 1; n <= 60; n++) begin
      if (prev === 1'b1 && bus.busy === 1'b0) falls++;
      prev = bus.busy;
      if (n == 34) begin
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL b2b_done_load: got busy %b want 0", bus.busy);
        else n_pass++;
      end
      // n==5 is mid-SHIFT, n==33 is the DONE cycle: both must be dropped.
      if (n == 5 || n == 33) begin
        bus.data_in = 32'd7;
        bus.mode    = (n == 33);
        bus.load    = 1'b1;
      end else bus.load = 1'b0;
      @(negedge clk_100);
    end
    bus.load = 1'b0;
    n_total++; if (falls != 1) $display("FAIL b2b_falls: got %0d want 1", falls); else n_pass++;
    m_val = 32'd987654; m_dec = 1; m_blank = 0; m_dp = 8'h01;
    check_round("b2b");
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] v;
    bit dec, bl;
    logic [7:0] dp;
    for (int it = 0; it < 10; it++) begin
      dec = 1'($urandom_range(0, 1));
      bl  = 1'($urandom_range(0, 1));
      dp  = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       v = $urandom;
        1:       v = $urandom % 100000000;
        2:       v = $urandom_range(0, 999);
        default: v = $urandom_range(0, 15);
      endcase
      drive_load(v, dec, bl, dp);
      wait_idle(to);
      n_total++; if (to) $display("FAIL rnd%0d_timeout: got busy stuck want idle", it); else n_pass++;
      m_val = v; m_dec = dec; m_blank = bl; m_dp = dp;
      cyc(2);
      n_total++;
      if (bus.ovf !== exp_ovf()) $display("FAIL rnd%0d_ovf: got %b want %b (v=%0d dec=%0d)", it, bus.ovf, exp_ovf(), v, dec);
      else n_pass++;
      check_round($sformatf("rnd%0d", it));
    end
  endtask

  task automatic test_reset_mid();
    drive_load(32'd12345678, 1, 1, 8'hFF);
    cyc(10);
    #2 rst = 1'b1;
    #1;
    n_total++; if (bus.tube_scan !== 8'h00) $display("FAIL midrst_scan: got %h want 00", bus.tube_scan); else n_pass++;
    n_total++; if (bus.tube_signal !== 8'h00) $display("FAIL midrst_seg: got %h want 00", bus.tube_signal); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else n_pass++;
    n_total++; if (bus.ovf !== 1'b0) $display("FAIL midrst_ovf: got %b want 0", bus.ovf); else n_pass++;
    model_reset();
    @(negedge clk_100);
    rst = 1'b0;
    @(negedge clk_100);
    n_total++; if (bus.tube_scan !== 8'h01) $display("FAIL midrst_first: got %h want 01", bus.tube_scan); else n_pass++;
    n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy2: got %b want 0", bus.busy); else n_pass++;
    check_round("midrst");
  endtask

  initial begin
    bus.data_in  = '0;
    bus.load     = 1'b0;
    bus.mode     = 1'b0;
    bus.blank_lz = 1'b0;
    bus.dp_mask  = '0;
    model_reset();
    test_reset();
    test_scan();
    test_hex();
    test_decimal();
    test_overflow();
    test_blank_dp();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
